// File: rtl/lock_controller.sv
// lock_controller
//   Central control FSM for the combination lock. It takes debounced keypad
//   pulses and produces the registered status codes shown on the
//   seven-segment display. It also holds the stored password, the digit-entry
//   buffer and the per-second countdown timer.
//
// Ports
//   Clk        in   system clock, rising edge
//   Rst_n      in   asynchronous active-low reset
//   key_valid  in   digit pulse, value on key_code (codes 10-15 ignored)
//   key_code   in   [3:0] digit value
//   key_enter  in   submit pulse
//   key_clear  in   discard entry / relock / abort password change
//   key_set    in   enter password-change mode (UNLOCKED only)
//   st_lock    out  [1:0] 00 LOCKED, 01 INPUT, 10 ALARM, 11 UNLOCKED (FSM state)
//   st_cd      out  [2:0] 000 idle, 001..110 = 5..0 countdown
//   st_set     out  1 while in password-change mode
//   st_err     out  [1:0] consecutive failed attempts
//
// Handshake: every key input is a one-cycle pulse with no back-pressure.
// It is sampled on the rising edge of Clk. The matching status change is
// visible right after that same edge. At most one key acts per cycle, with
// priority clear > enter > set > digit. Lower-priority pulses in the same
// cycle are dropped.
module lock_controller #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter logic [15:0] DEFAULT_PWD   = 16'h1234
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       key_enter,
  input  logic       key_clear,
  input  logic       key_set,
  output logic [1:0] st_lock,
  output logic [2:0] st_cd,
  output logic       st_set,
  output logic [1:0] st_err
);

  localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    S_LOCKED   = 2'b00,
    S_INPUT    = 2'b01,
    S_ALARM    = 2'b10,
    S_UNLOCKED = 2'b11
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_cd,    w_cd_nxt;
  logic            r_set,   w_set_nxt;
  logic [1:0]      r_err,   w_err_nxt;
  logic [15:0]     r_pwd,   w_pwd_nxt;
  logic [15:0]     r_buf,   w_buf_nxt;
  logic [2:0]      r_cnt,   w_cnt_nxt;
  logic [TW-1:0]   r_tick,  w_tick_nxt;

  logic            w_digit_ok;
  logic            w_can_shift;
  logic [15:0]     w_buf_shift;
  logic            w_tick_wrap;
  logic            w_expire;

  assign w_digit_ok  = key_valid && (key_code <= 4'd9);
  assign w_can_shift = w_digit_ok && (r_cnt < 3'd4);
  assign w_buf_shift = {r_buf[11:0], key_code};
  assign w_tick_wrap = (r_tick == TICK_MAX);
  // Expiry is one full period after the countdown reaches code 110.
  assign w_expire    = w_tick_wrap && (r_cd == 3'd6);

  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = r_cd;
    w_set_nxt   = r_set;
    w_err_nxt   = r_err;
    w_pwd_nxt   = r_pwd;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_tick_nxt  = r_tick;

    case (r_state)
      S_LOCKED: begin
        // Clear, enter and set are absorbed here. They still block a
        // same-cycle digit because of the key priority.
        if (!key_clear && !key_enter && !key_set && w_digit_ok) begin
          w_buf_nxt   = {12'h000, key_code};
          w_cnt_nxt   = 3'd1;
          w_state_nxt = S_INPUT;
        end
      end

      S_INPUT: begin
        if (key_clear) begin
          w_buf_nxt   = 16'h0000;
          w_cnt_nxt   = 3'd0;
          w_state_nxt = S_LOCKED;
        end else if (key_enter) begin
          w_buf_nxt = 16'h0000;
          w_cnt_nxt = 3'd0;
          if ((r_cnt == 3'd4) && (r_buf == r_pwd)) begin
            w_state_nxt = S_UNLOCKED;
            w_err_nxt   = 2'd0;
            w_cd_nxt    = 3'd1;
            w_tick_nxt  = '0;
          end else begin
            w_err_nxt = r_err + 2'd1;
            if (r_err == 2'd2) begin
              w_state_nxt = S_ALARM;
              w_cd_nxt    = 3'd1;
              w_tick_nxt  = '0;
            end else begin
              w_state_nxt = S_LOCKED;
            end
          end
        end else if (!key_set && w_can_shift) begin
          w_buf_nxt = w_buf_shift;
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end

      S_UNLOCKED: begin
        if (r_set) begin
          // Password edit. The countdown stays frozen while r_set is high.
          if (key_clear) begin
            w_set_nxt = 1'b0;
            w_buf_nxt = 16'h0000;
            w_cnt_nxt = 3'd0;
          end else if (key_enter) begin
            if (r_cnt == 3'd4) begin
              w_pwd_nxt  = r_buf;
              w_set_nxt  = 1'b0;
              w_buf_nxt  = 16'h0000;
              w_cnt_nxt  = 3'd0;
              w_cd_nxt   = 3'd1;
              w_tick_nxt = '0;
            end
          end else if (!key_set && w_can_shift) begin
            w_buf_nxt = w_buf_shift;
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end else if (key_clear || w_expire) begin
          w_state_nxt = S_LOCKED;
          w_cd_nxt    = 3'd0;
          w_tick_nxt  = '0;
        end else begin
          if (w_tick_wrap) begin
            w_tick_nxt = '0;
            w_cd_nxt   = r_cd + 3'd1;
          end else begin
            w_tick_nxt = r_tick + TW'(1);
          end
          // Enter outranks set, so a same-cycle enter swallows the set.
          if (!key_enter && key_set) begin
            w_set_nxt = 1'b1;
            w_buf_nxt = 16'h0000;
            w_cnt_nxt = 3'd0;
          end
        end
      end

      S_ALARM: begin
        if (w_expire) begin
          w_state_nxt = S_LOCKED;
          w_cd_nxt    = 3'd0;
          w_tick_nxt  = '0;
          w_err_nxt   = 2'd0;
        end else if (w_tick_wrap) begin
          w_tick_nxt = '0;
          w_cd_nxt   = r_cd + 3'd1;
        end else begin
          w_tick_nxt = r_tick + TW'(1);
        end
      end

      default: w_state_nxt = S_LOCKED;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_LOCKED;
      r_cd    <= 3'd0;
      r_set   <= 1'b0;
      r_err   <= 2'd0;
      r_pwd   <= DEFAULT_PWD;
      r_buf   <= 16'h0000;
      r_cnt   <= 3'd0;
      r_tick  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cd    <= w_cd_nxt;
      r_set   <= w_set_nxt;
      r_err   <= w_err_nxt;
      r_pwd   <= w_pwd_nxt;
      r_buf   <= w_buf_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  assign st_lock = r_state;
  assign st_cd   = r_cd;
  assign st_set  = r_set;
  assign st_err  = r_err;

endmodule
